display_driver_7seg: RTL and testbench

Downstream consumer of the calculator's 16-bit ToDisplay value; drives the board's 8-digit multiplexed 7-segment display.

---
 rtl/display_pkg.sv | 31 +++
 rtl/display_driver_7seg_hex_to_7seg.sv | 12 +
 rtl/display_driver_7seg.sv | 144 ++++++++++++++
 tb/tb_display_driver_7seg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and the segment glyph table for the 7-segment display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam int BCD_DIGITS = 5;
  localparam int N_ANODES   = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}; A-F render as A,b,C,d,E,F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_add3(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [4*BCD_DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/display_driver_7seg_hex_to_7seg.sv
// Nibble to active-low 7-segment glyph, with a blank override for unlit digits.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : SEG_LUT[i_nibble];

endmodule

// File: rtl/display_driver_7seg.sv
// 8-digit multiplexed 7-segment driver: hex or sequential double-dabble decimal conversion,
// tear-free display register, and a prescaled digit scanner.
module display_driver_7seg
  import display_pkg::*;
#(
  parameter int N           = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] value,
  input  logic         dec_mode,
  output logic [7:0]   an,
  output logic [6:0]   seg,
  output logic         dp,
  output logic         busy
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_t         r_state;
  logic [N-1:0]        r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [3:0]          r_cnt;
  logic                r_mode;
  logic                r_busy;
  logic [BCD_W-1:0]    r_disp;
  logic [N_ANODES-1:0] r_mask;

  logic [PW-1:0]       r_presc;
  logic [2:0]          r_idx;
  logic [7:0]          r_an;
  logic [6:0]          r_seg;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [N_ANODES-1:0] w_dec_mask;
  logic [3:0]          w_nibble;
  logic                w_blank;
  logic [6:0]          w_seg;

  assign w_bcd_adj = bcd_add3(r_bcd);

  // Leading-zero blanking: digit k lights if any digit at or above k is nonzero.
  always_comb begin
    logic w_any;
    w_any      = 1'b0;
    w_dec_mask = '0;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      w_any         = w_any | (r_bcd[k*4 +: 4] != 4'h0);
      w_dec_mask[k] = w_any;
    end
    w_dec_mask[0] = 1'b1;
  end

  // Converter FSM; display register and mask only ever change together in LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_disp  <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bin   <= value;
          r_mode  <= dec_mode;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_busy  <= dec_mode;
          r_state <= dec_mode ? SHIFT : LATCH;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= LATCH;
            r_busy  <= 1'b0;
          end
        end
        LATCH: begin
          if (r_mode) begin
            r_disp <= r_bcd;
            r_mask <= w_dec_mask;
          end else begin
            r_disp <= {4'h0, r_bin};
            r_mask <= 8'h0F;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      3'd0:    w_nibble = r_disp[3:0];
      3'd1:    w_nibble = r_disp[7:4];
      3'd2:    w_nibble = r_disp[11:8];
      3'd3:    w_nibble = r_disp[15:12];
      3'd4:    w_nibble = r_disp[19:16];
      default: w_nibble = 4'h0;
    endcase
  end

  assign w_blank = !r_mask[r_idx] || (r_idx > 3'd4);

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  // Scanner: an/seg follow the digit index one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
      r_an    <= 8'hFF;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_presc == PW'(REFRESH_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_an  <= r_mask[r_idx] ? ~(8'b1 << r_idx) : 8'hFF;
      r_seg <= w_seg;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;
  assign busy = r_busy;

endmodule

// File: tb/tb_display_driver_7seg.sv
// Directed bench for display_driver_7seg with a short refresh divider so full scans are cheap.
module tb_display_driver_7seg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        dec_mode = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] scan_lit;
  logic [6:0] scan_seg [8];
  int         scan_bad;
  int         scan_busy;

  display_driver_7seg #(.N(16), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .dec_mode (dec_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Records which digits light up and the glyph each one shows over n cycles.
  task automatic scan(input int n);
    scan_lit  = 8'h00;
    scan_bad  = 0;
    scan_busy = 0;
    for (int i = 0; i < 8; i++) scan_seg[i] = 7'h7F;
    repeat (n) begin
      @(negedge clk);
      if (busy) scan_busy++;
      if (an != 8'hFF) begin
        if ($countones(~an) != 1) scan_bad++;
        else begin
          for (int k = 0; k < 8; k++) begin
            if (!an[k]) begin
              scan_lit[k] = 1'b1;
              scan_seg[k] = seg;
            end
          end
        end
      end else if (seg != 7'h7F) begin
        scan_bad++;
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int t;
    t = 0;
    while (busy !== lvl && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(busy), 32'(lvl));
  endtask

  initial begin
    int n;
    int t;
    logic [7:0] e_an;

    // Reset state
    step(3);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);

    // Zero in decimal: only digit 0 lit, glyph 0
    value = 16'h0000;
    dec_mode = 1'b1;
    reset = 1'b0;
    step(36);
    scan(40);
    check("zero_lit", 32'(scan_lit), 32'h01);
    check("zero_seg0", 32'(scan_seg[0]), 32'h40);
    check("zero_bad", scan_bad, 0);

    // 65535 decimal: busy run length, gap, glyphs 6,5,5,3,5
    value = 16'hFFFF;
    step(36);
    wait_busy(1'b0, "max_wait_lo");
    wait_busy(1'b1, "max_wait_hi");
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", n, 16);
    n = 0;
    while (!busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_gap", n, 2);
    scan(40);
    check("max_lit", 32'(scan_lit), 32'h1F);
    check("max_seg0", 32'(scan_seg[0]), 32'h12);
    check("max_seg1", 32'(scan_seg[1]), 32'h30);
    check("max_seg2", 32'(scan_seg[2]), 32'h12);
    check("max_seg3", 32'(scan_seg[3]), 32'h12);
    check("max_seg4", 32'(scan_seg[4]), 32'h02);
    check("max_bad", scan_bad, 0);

    // Scan order: 4 cycles per digit, 0..7 then wrap, blank beyond digit 4
    t = 0;
    while (an == 8'hFE && t < 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (an != 8'hFE && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("order_sync", 32'(an), 32'hFE);
    for (int c = 0; c <= 32; c++) begin
      e_an = 8'hFF;
      if (((c / 4) % 8) < 5) e_an[(c / 4) % 8] = 1'b0;
      check("order_an", 32'(an), 32'(e_an));
      @(negedge clk);
    end

    // Hex BEEF: b,E,E,F on digits 3..0, busy never rises
    value = 16'hBEEF;
    dec_mode = 1'b0;
    step(24);
    scan(40);
    check("beef_lit", 32'(scan_lit), 32'h0F);
    check("beef_seg3", 32'(scan_seg[3]), 32'h03);
    check("beef_seg2", 32'(scan_seg[2]), 32'h06);
    check("beef_seg1", 32'(scan_seg[1]), 32'h06);
    check("beef_seg0", 32'(scan_seg[0]), 32'h0E);
    check("beef_busy", scan_busy, 0);

    // Hex latency and no zero-blanking in hex
    value = 16'h00A5;
    step(4);
    scan(32);
    check("a5_lit", 32'(scan_lit), 32'h0F);
    check("a5_seg0", 32'(scan_seg[0]), 32'h12);
    check("a5_seg1", 32'(scan_seg[1]), 32'h08);
    check("a5_seg2", 32'(scan_seg[2]), 32'h40);
    check("a5_seg3", 32'(scan_seg[3]), 32'h40);

    // Value change during SHIFT cycle 5 does not tear the current result
    value = 16'd1234;
    dec_mode = 1'b1;
    step(40);
    wait_busy(1'b0, "tear_wait_lo");
    wait_busy(1'b1, "tear_wait_hi");
    step(4);
    value = 16'd9;
    wait_busy(1'b0, "tear_wait_latch");
    step(1);
    check("tear_disp_old", 32'(dut.r_disp), 32'h01234);
    check("tear_mask_old", 32'(dut.r_mask), 32'h0F);
    step(18);
    check("tear_disp_new", 32'(dut.r_disp), 32'h00009);
    check("tear_mask_new", 32'(dut.r_mask), 32'h01);
    scan(40);
    check("nine_lit", 32'(scan_lit), 32'h01);
    check("nine_seg0", 32'(scan_seg[0]), 32'h10);

    // One-cycle reset pulse mid-SHIFT
    value = 16'hFFFF;
    step(40);
    wait_busy(1'b0, "rp_wait_lo");
    wait_busy(1'b1, "rp_wait_hi");
    step(3);
    reset = 1'b1;
    step(1);
    check("rp_an", 32'(an), 32'hFF);
    check("rp_seg", 32'(seg), 32'h7F);
    check("rp_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step(17);
    check("rp_mask_early", 32'(dut.r_mask), 32'h00);
    step(1);
    check("rp_mask_back", 32'(dut.r_mask), 32'h1F);
    check("rp_disp_back", 32'(dut.r_disp), 32'h65535);
    scan(40);
    check("rp_lit", 32'(scan_lit), 32'h1F);
    check("rp_seg4", 32'(scan_seg[4]), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
